// File: rtl/iic_slave_rx.sv
// Write-only I2C target: oversampled START/STOP/bit decoding, address match with ACK,
// control-byte mode latch and payload streaming with a command/data flag.
module iic_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b0111100,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       iic_scl,
    input  logic       iic_sda_in,
    output logic       iic_sda_oe,
    input  logic       rx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ctrl,
    output logic       rx_overflow,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, CTRL, CTRL_ACK, DATA, DATA_ACK, IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   ack_pend_q, ack_pend_d;
    logic                   mode_q, mode_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   busy_q, busy_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_overflow_q, rx_overflow_d;
    logic                   frame_done_q, frame_done_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_ctrl_q, rx_ctrl_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // Our own ACK pulls SDA low; it must never be mistaken for a START.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s & ~sda_oe_q;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};

    // NOTE: every register here is plain state (no RAM), so all of it is reset;
    // the synchronizers reset to 1 so an idle bus produces no spurious edges.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scl_sync_q    <= '1;
            sda_sync_q    <= '1;
            scl_prev_q    <= 1'b1;
            sda_prev_q    <= 1'b1;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            ack_pend_q    <= 1'b0;
            mode_q        <= 1'b0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_overflow_q <= 1'b0;
            frame_done_q  <= 1'b0;
            rx_data_q     <= '0;
            rx_ctrl_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
            // which is what makes the synchronizer chain a chain.
            scl_sync_q    <= {scl_sync_q[SYNC_STAGES-2:0], iic_scl};
            sda_sync_q    <= {sda_sync_q[SYNC_STAGES-2:0], iic_sda_in};
            scl_prev_q    <= scl_s;
            sda_prev_q    <= sda_s;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            ack_pend_q    <= ack_pend_d;
            mode_q        <= mode_d;
            sda_oe_q      <= sda_oe_d;
            busy_q        <= busy_d;
            rx_valid_q    <= rx_valid_d;
            rx_overflow_q <= rx_overflow_d;
            frame_done_q  <= frame_done_d;
            rx_data_q     <= rx_data_d;
            rx_ctrl_q     <= rx_ctrl_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        ack_pend_d    = ack_pend_q;
        mode_d        = mode_q;
        sda_oe_d      = sda_oe_q;
        busy_d        = busy_q;
        rx_valid_d    = 1'b0;
        rx_overflow_d = 1'b0;
        frame_done_d  = 1'b0;
        rx_data_d     = rx_data_q;
        rx_ctrl_d     = rx_ctrl_q;

        if (start_det) begin
            state_d    = ADDR;
            bit_cnt_d  = '0;
            ack_pend_d = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else if (stop_det) begin
            state_d      = IDLE;
            ack_pend_d   = 1'b0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            frame_done_d = busy_q;
        end else begin
            unique case (state_q)
                ADDR, CTRL, DATA: begin
                    if (scl_rise && !ack_pend_q) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR && !rx_byte[0]) ack_pend_d = 1'b1;
                                else                                           state_d    = IGNORE;
                            end else if (state_q == CTRL) begin
                                mode_d     = rx_byte[6];
                                ack_pend_d = 1'b1;
                            end else if (rx_ready) begin
                                rx_valid_d = 1'b1;
                                rx_data_d  = rx_byte;
                                rx_ctrl_d  = ~mode_q;
                                ack_pend_d = 1'b1;
                            end else begin
                                rx_overflow_d = 1'b1;
                                state_d       = IGNORE;
                            end
                        end
                    end else if (scl_fall && ack_pend_q) begin
                        // The fall that ends bit 7 opens the ACK slot.
                        ack_pend_d = 1'b0;
                        sda_oe_d   = 1'b1;
                        if (state_q == ADDR) begin
                            busy_d  = 1'b1;
                            state_d = ADDR_ACK;
                        end else if (state_q == CTRL) begin
                            state_d = CTRL_ACK;
                        end else begin
                            state_d = DATA_ACK;
                        end
                    end
                end
                ADDR_ACK, CTRL_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = (state_q == ADDR_ACK) ? CTRL : DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign iic_sda_oe  = sda_oe_q;
    assign busy        = busy_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overflow = rx_overflow_q;
    assign frame_done  = frame_done_q;
    assign rx_data     = rx_data_q;
    assign rx_ctrl     = rx_ctrl_q;

endmodule

// File: tb/tb_iic_slave_rx.sv
// Bench for iic_slave_rx: a bit-banged bus master with open-drain SDA, a frame-level
// reference model of ACKs/deliveries, directed plan frames and random frames.
module tb_iic_slave_rx;

    localparam logic [6:0] SLAVE_ADDR = 7'b0111100;
    localparam int         Q          = 8;  // quarter SCL period in sys_clk cycles

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       iic_scl;
    logic       sda_m;
    logic       iic_sda_in;
    logic       iic_sda_oe;
    logic       rx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ctrl;
    logic       rx_overflow;
    logic       busy;
    logic       frame_done;

    // Open-drain bus: low if either side pulls low.
    assign iic_sda_in = sda_m & ~iic_sda_oe;

    iic_slave_rx #(.SLAVE_ADDR(SLAVE_ADDR), .SYNC_STAGES(2)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .iic_scl    (iic_scl),
        .iic_sda_in (iic_sda_in),
        .iic_sda_oe (iic_sda_oe),
        .rx_ready   (rx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ctrl    (rx_ctrl),
        .rx_overflow(rx_overflow),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations collected by the monitor.
    logic [8:0] got_q[$];
    int         ovf_cnt, fd_cnt;
    bit         busy_seen, oe_seen;

    // Expectations built by the frame-level model.
    logic [8:0] exp_q[$];
    int         exp_ovf;
    bit         exp_oe, exp_busy, last_addr_ok;

    logic [7:0] frame_b[8];
    bit         frame_r[8];

    always @(negedge sys_clk) begin
        if (rx_valid)    got_q.push_back({rx_ctrl, rx_data});
        if (rx_overflow) ovf_cnt++;
        if (frame_done)  fd_cnt++;
        if (busy)        busy_seen = 1'b1;
        if (iic_sda_oe)  oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1;   tick(Q);
        iic_scl = 1'b1; tick(Q);
        sda_m = 1'b0;   tick(Q);
        iic_scl = 1'b0; tick(Q);
    endtask

    task automatic m_stop();
        sda_m = 1'b0;   tick(Q);
        iic_scl = 1'b1; tick(Q);
        sda_m = 1'b1;   tick(2 * Q);
    endtask

    task automatic m_bit(input logic b);
        sda_m = b;      tick(Q);
        iic_scl = 1'b1; tick(2 * Q);
        iic_scl = 1'b0; tick(Q);
    endtask

    task automatic m_ack_slot(output logic ack);
        sda_m = 1'b1;   tick(Q);
        iic_scl = 1'b1; tick(Q);
        ack = (iic_sda_in == 1'b0);
        tick(Q);
        iic_scl = 1'b0; tick(Q);
    endtask

    task automatic m_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) m_bit(b[i]);
        m_ack_slot(ack);
    endtask

    task automatic begin_txn();
        got_q.delete();
        exp_q.delete();
        ovf_cnt = 0; fd_cnt = 0; busy_seen = 0; oe_seen = 0;
        exp_ovf = 0; exp_oe = 0; exp_busy = 0; last_addr_ok = 0;
    endtask

    // One START-delimited segment; the model applies the frame rules byte by byte.
    task automatic send_segment(input string tag, input int n);
        bit   addr_ok, alive, data_mode, exp_ack;
        logic ack;
        m_start();
        addr_ok   = (frame_b[0] == {SLAVE_ADDR, 1'b0});
        alive     = addr_ok;
        data_mode = 1'b0;
        for (int k = 0; k < n; k++) begin
            rx_ready = frame_r[k];
            if (k == 0) begin
                exp_ack = addr_ok;
            end else if (k == 1) begin
                exp_ack = alive;
                data_mode = frame_b[1][6];
            end else if (alive && frame_r[k]) begin
                exp_ack = 1'b1;
                exp_q.push_back({~data_mode, frame_b[k]});
            end else begin
                exp_ack = 1'b0;
                if (alive) exp_ovf++;
                alive = 1'b0;
            end
            m_byte(frame_b[k], ack);
            check($sformatf("%s ack byte%0d", tag, k), ack, exp_ack);
            if (exp_ack) exp_oe = 1'b1;
        end
        if (addr_ok) exp_busy = 1'b1;
        last_addr_ok = addr_ok;
    endtask

    task automatic end_txn(input string tag);
        m_stop();
        tick(4);
        check({tag, " rx count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s rx%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, " overflow"},   ovf_cnt, exp_ovf);
        check({tag, " frame_done"}, fd_cnt, last_addr_ok);
        check({tag, " busy seen"},  busy_seen, exp_busy);
        check({tag, " oe seen"},    oe_seen, exp_oe);
        check({tag, " busy idle"},  busy, 1'b0);
    endtask

    task automatic load(input logic [7:0] b[8], input bit r[8]);
        frame_b = b;
        frame_r = r;
    endtask

    initial begin
        logic ack;
        sys_rst = 1'b1; iic_scl = 1'b1; sda_m = 1'b1; rx_ready = 1'b1;
        begin_txn();
        tick(5);
        sys_rst = 1'b0;
        tick(5);
        check("reset sda_oe",      iic_sda_oe, 1'b0);
        check("reset rx_valid",    rx_valid, 1'b0);
        check("reset rx_data",     rx_data, 8'h00);
        check("reset rx_ctrl",     rx_ctrl, 1'b0);
        check("reset rx_overflow", rx_overflow, 1'b0);
        check("reset busy",        busy, 1'b0);
        check("reset frame_done",  frame_done, 1'b0);

        // Command frame.
        begin_txn();
        load('{8'h78, 8'h00, 8'hAF, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 1, 1, 1});
        send_segment("cmd", 3);
        end_txn("cmd");

        // Multi-byte data frame.
        begin_txn();
        load('{8'h78, 8'h40, 8'h12, 8'h34, 8'h56, 0, 0, 0}, '{1, 1, 1, 1, 1, 1, 1, 1});
        send_segment("data3", 5);
        end_txn("data3");

        // Wrong address.
        begin_txn();
        load('{8'h7A, 8'h00, 8'h55, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 1, 1, 1});
        send_segment("badaddr", 3);
        end_txn("badaddr");

        // Read request to our address.
        begin_txn();
        load('{8'h79, 8'h40, 8'h66, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 1, 1, 1});
        send_segment("read", 3);
        end_txn("read");

        // Consumer stalls on the second payload byte.
        begin_txn();
        load('{8'h78, 8'h40, 8'h11, 8'h22, 0, 0, 0, 0}, '{1, 1, 1, 0, 1, 1, 1, 1});
        send_segment("ovf", 4);
        end_txn("ovf");
        rx_ready = 1'b1;

        // Repeated START after the control byte.
        begin_txn();
        load('{8'h78, 8'h40, 0, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 1, 1, 1});
        send_segment("rs_a", 2);
        load('{8'h78, 8'h00, 8'h8D, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 1, 1, 1});
        send_segment("rs_b", 3);
        end_txn("rstart");

        // Reset while the first half of a payload byte (all ones) is on the wire.
        begin_txn();
        m_start();
        m_byte(8'h78, ack);
        check("rst addr ack", ack, 1'b1);
        m_byte(8'h00, ack);
        check("rst ctrl ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) m_bit(1'b1);
        check("rst busy before", busy, 1'b1);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        check("rst sda_oe",   iic_sda_oe, 1'b0);
        check("rst rx_data",  rx_data, 8'h00);
        check("rst rx_ctrl",  rx_ctrl, 1'b0);
        check("rst busy",     busy, 1'b0);
        check("rst rx_valid", rx_valid, 1'b0);
        check("rst rx_ovf",   rx_overflow, 1'b0);
        for (int i = 0; i < 4; i++) m_bit(1'b0);
        m_ack_slot(ack);
        check("rst payload ack", ack, 1'b0);
        m_stop();
        tick(4);
        check("rst frame_done", fd_cnt, 0);
        check("rst rx count",   got_q.size(), 0);

        // Random frames.
        for (int f = 0; f < 8; f++) begin
            int sel, n;
            logic [7:0] b[8];
            bit r[8];
            sel = $urandom_range(0, 5);
            b[0] = (sel < 4) ? 8'h78 : (sel == 4) ? 8'h7A : 8'h79;
            b[1] = 8'($urandom);
            n = 2 + $urandom_range(1, 4);
            for (int k = 0; k < 8; k++) begin
                if (k >= 2) b[k] = 8'($urandom);
                r[k] = ($urandom_range(0, 4) != 0);
            end
            begin_txn();
            load(b, r);
            send_segment($sformatf("rnd%0d", f), n);
            end_txn($sformatf("rnd%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iic_slave_rx.md
Name: iic_slave_rx

Overview:
- I2C write-only target (responder) for the OLED link. It is the receiving end of the IIC master's address → control → payload → stop framing.
- Oversamples SCL/SDA on sys_clk, detects START/STOP, matches the 7-bit address and ACKs by pulling SDA low.
- Decodes the control byte (0x00 = command, 0x40 = data) and streams each payload byte out with a command/data flag.
- Used as a bench/loopback model and as the front end of the OLED command/pixel capture logic.

Parameters:
- SLAVE_ADDR, 7'b0111100, 7-bit address the block responds to.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA; legal range 2–3.

Ports:
- sys_clk  in  1  system clock; 50 MHz nominal, ≥ 16× SCL rate.
- sys_rst  in  1  synchronous, active-high reset.
- iic_scl  in  1  bus SCL, asynchronous.
- iic_sda_in  in  1  bus SDA as read from the pad, asynchronous.
- iic_sda_oe  out  1  1 = drive SDA low (ACK); 0 = release. The pad is open-drain.
- rx_ready  in  1  consumer can accept a payload byte.
- rx_valid  out  1  one-cycle pulse; rx_data/rx_ctrl are valid in that cycle.
- rx_data  out  8  received payload byte, MSB first on the wire.
- rx_ctrl  out  1  1 = command byte, 0 = data byte (same convention as iic_w_ctrl).
- rx_overflow  out  1  one-cycle pulse when a payload byte is NACKed because rx_ready = 0.
- busy  out  1  high from an address match until STOP or START.
- frame_done  out  1  one-cycle pulse on STOP ending an addressed frame.

Behaviour:
- Reset values: iic_sda_oe, rx_valid, rx_overflow, busy and frame_done = 0; rx_data = 0x00; rx_ctrl = 0; state = IDLE.
- Synchronizers are reset to 1 (idle bus).
- Edge detection:
  - SCL and SDA pass through SYNC_STAGES flops plus one history flop.
  - Events scl_rise, scl_fall, START (SDA fall while SCL = 1) and STOP (SDA rise while SCL = 1) are single-cycle.
  - Each event fires SYNC_STAGES+1 sys_clk cycles after the pin transition.
- Bit sampling: on scl_rise, shift sdа into an 8-bit shift register, MSB first; bit_cnt counts 0..7. bit_cnt = 7 on a rise completes a byte.
- States:
  - IDLE → ADDR on START.
  - ADDR: on byte complete, evaluate byte[7:1] == SLAVE_ADDR and byte[0] == 0.
    - Match: at the next scl_fall set iic_sda_oe = 1 and busy = 1, go to ADDR_ACK.
    - No match or R/W = 1: go to IGNORE with no ACK.
  - ADDR_ACK: at scl_fall, iic_sda_oe = 0, bit_cnt = 0, go to CTRL.
  - CTRL: on byte complete, latch mode = byte[6] (0 → command, 1 → data); all other bits are ignored. ACK at the next scl_fall, go to CTRL_ACK.
  - CTRL_ACK: at scl_fall, release SDA, go to DATA.
  - DATA: on byte complete:
    - If rx_ready = 1: pulse rx_valid, drive rx_data = byte and rx_ctrl = ~mode in the same cycle, ACK at the next scl_fall, go to DATA_ACK.
    - If rx_ready = 0: pulse rx_overflow, no ACK, go to IGNORE.
  - DATA_ACK: at scl_fall, release SDA, return to DATA. Multiple payload bytes per frame are allowed.
  - IGNORE: SDA stays released; wait for START or STOP.
- START in any state (repeated start) → ADDR, bit_cnt = 0, iic_sda_oe = 0, busy = 0.
- STOP in any state → IDLE, iic_sda_oe = 0, busy = 0. frame_done pulses only if busy was 1.
- START/STOP have priority over scl edges occurring in the same cycle.
- rx_data holds its value between pulses.
- While iic_sda_oe = 1, the sampled SDA low must not be decoded as START. SCL is high only between the ACK rise and the ACK fall, and SDA does not change while we drive it.
- Reset mid-frame: returns immediately to IDLE with SDA released. The remainder of that frame is not decoded until the next START.

Test Plan:
- Master frame START, 0x78, 0x00, 0xAF, STOP with rx_ready = 1 → ACK driven on all 3 ACK slots; one rx_valid with rx_data = 0xAF, rx_ctrl = 1; frame_done pulses once.
- START, 0x78, 0x40, 0x12, 0x34, 0x56, STOP → three rx_valid pulses in order 0x12, 0x34, 0x56, each with rx_ctrl = 0; 5 ACKs total.
- Address 0x7A (wrong address) → no ACK, iic_sda_oe stays 0, no rx_valid, busy stays 0, no frame_done.
- Address 0x79 (R/W = 1) → NACK, IGNORE until STOP.
- rx_ready = 0 during the second data byte of 0x40, 0x11, 0x22 → 0x11 delivered; rx_overflow pulses on 0x22; 0x22 NACKed and not output.
- Repeated START after the control byte, then 0x78, 0x00, 0x8D, STOP → decodes 0x8D as a command.
- sys_rst asserted mid-payload → all outputs return to reset values next cycle.
